// File: rtl/spike_dec_pkg.sv
// Shared types and saturating-arithmetic helpers for the spike rate decoder.
package spike_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 8;

  // Largest value representable in a w-bit counter (w up to 32).
  function automatic logic [31:0] cnt_max(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  localparam logic [31:0] CNT_MAX = cnt_max(CNT_W_DEF);

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter
  import spike_dec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [31:0] MAX = cnt_max(W);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else            q <= W'(sat_inc(32'(q), {31'd0, inc}, MAX));
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts spikes per WINDOW_LEN-cycle window and
// presents each count on a valid/ready slot. Define SPIKE_ISI_EN for ISI output.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spike,
  input  logic             ovr_clr,
  input  logic             rate_ready,
  output logic             rate_valid,
  output logic [CNT_W-1:0] rate_data,
  output logic             overrun,
  output logic             isi_valid,
  output logic [CNT_W-1:0] isi_data
);

  localparam int               WIN_W    = $clog2(WINDOW_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [31:0]      MAX      = cnt_max(CNT_W);

  state_e           state, state_nx;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] win_total;
  logic             counting;
  logic             window_end;
  logic             cnt_clear;
  logic             slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    counting   = 1'b0;
    window_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (ena) state_nx = COUNT;
      end
      COUNT: begin
        counting   = 1'b1;
        window_end = (win_cnt == WIN_LAST);
        if (!ena) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters restart on window end, and on leaving COUNT the partial window is dropped.
  assign cnt_clear = !counting || !ena || window_end;
  assign win_total = CNT_W'(sat_inc(32'(spike_cnt), {31'd0, spike}, MAX));
  assign slot_free = !rate_valid || rate_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            win_cnt <= '0;
    else if (cnt_clear) win_cnt <= '0;
    else                win_cnt <= win_cnt + 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_spike_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (spike),
    .q     (spike_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_valid <= 1'b0;
      rate_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (window_end && slot_free) begin
        rate_valid <= 1'b1;
        rate_data  <= win_total;
      end else if (rate_ready) begin
        rate_valid <= 1'b0;
      end
      // A dropped result outranks a same-cycle clear.
      if (window_end && !slot_free) overrun <= 1'b1;
      else if (ovr_clr)             overrun <= 1'b0;
    end
  end

`ifdef SPIKE_ISI_EN
  logic [CNT_W-1:0] gap;
  logic             seen;
  logic             gap_clear;
  logic             isi_fire;

  assign gap_clear = !counting || spike;
  assign isi_fire  = counting && spike && seen;

  sat_counter #(.W(CNT_W)) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (gap_clear),
    .inc   (1'b1),
    .q     (gap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= 1'b0;
      isi_valid <= 1'b0;
      isi_data  <= '0;
    end else begin
      isi_valid <= isi_fire;
      // gap is 0 on the cycle after a spike, so the interval is gap+1.
      if (isi_fire) isi_data <= CNT_W'(sat_inc(32'(gap), 32'd1, MAX));
      if (!counting)  seen <= 1'b0;
      else if (spike) seen <= 1'b1;
    end
  end
`else
  assign isi_valid = 1'b0;
  assign isi_data  = '0;
`endif

endmodule
